// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares a single uart_tx between NUM_REQ byte streams.
// It optionally sends a channel-ID header before each packet and times out if busy never rises.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter bit HDR_EN  = 1'b1,
    parameter int BUSY_TO = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     ch_enable,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [2:0]             grant_id,
    output logic                   grant_active,
    output logic                   pkt_done,
    output logic                   to_err
);

    localparam int CW = $clog2(BUSY_TO + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_grant;
    logic               r_active;
    logic [NUM_REQ-1:0] r_ready;
    logic               r_send;
    logic [7:0]         r_data;
    logic [7:0]         r_byte;
    logic               r_last;
    logic               r_is_hdr;
    logic               r_done;
    logic               r_err;
    logic [CW-1:0]      r_cnt;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [2:0]         w_pick;
    int                 w_best;
    int                 w_dist;
    logic [NUM_REQ-1:0] w_pick_mask;
    logic [NUM_REQ-1:0] w_grant_mask;
    logic               w_gvalid;
    logic [7:0]         w_gdata;
    logic               w_glast;

    assign w_elig = req_valid & ch_enable;

    // Round-robin: the eligible channel closest after r_ptr (cyclically) wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + 2 * NUM_REQ - int'(r_ptr) - 1) % NUM_REQ;
            if (w_elig[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_pick  = 3'(j);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_pick_mask  = '0;
        w_grant_mask = '0;
        w_gvalid     = 1'b0;
        w_gdata      = 8'h00;
        w_glast      = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_pick_mask[j]  = (w_pick == 3'(j));
            w_grant_mask[j] = (r_grant == 3'(j));
            if (r_grant == 3'(j)) begin
                w_gvalid = req_valid[j];
                w_gdata  = req_data[8*j +: 8];
                w_glast  = req_last[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 3'(NUM_REQ - 1);
            r_grant  <= '0;
            r_active <= 1'b0;
            r_ready  <= '0;
            r_send   <= 1'b0;
            r_data   <= '0;
            r_byte   <= '0;
            r_last   <= 1'b0;
            r_is_hdr <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_send <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_pick;
                        r_active <= 1'b1;
                        if (HDR_EN) begin
                            r_state <= S_HDR;
                        end else begin
                            r_ready <= w_pick_mask;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HDR: begin
                    if (!tx_busy) begin
                        r_data   <= {4'hA, 1'b0, r_grant};
                        r_send   <= 1'b1;
                        r_is_hdr <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT_HI;
                    end
                end
                S_FETCH: begin
                    // Ready is already high for the granted channel, so valid alone completes the handshake.
                    if (w_gvalid) begin
                        r_byte   <= w_gdata;
                        r_last   <= w_glast;
                        r_is_hdr <= 1'b0;
                        r_ready  <= '0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        r_data  <= r_byte;
                        r_send  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_cnt == CW'(BUSY_TO - 1)) begin
                        r_err    <= 1'b1;
                        r_active <= 1'b0;
                        r_ptr    <= r_grant;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_is_hdr || !r_last) begin
                            r_ready <= w_grant_mask;
                            r_state <= S_FETCH;
                        end else begin
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_ptr    <= r_grant;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = r_ready;
    assign tx_send      = r_send;
    assign tx_data      = r_data;
    assign grant_id     = r_grant;
    assign grant_active = r_active;
    assign pkt_done     = r_done;
    assign to_err       = r_err;

endmodule
